// File: rtl/user_sprite_writer.sv
// Sprite RAM write-side loader: raster pixel stream in, addressed RAM writes out.
// Define USER_SPRITE_WRITER_MIRROR_EN to honour `flip` (horizontal mirroring).
module user_sprite_writer #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load_start,
    input  logic [9:0]        user_sizeX,
    input  logic [9:0]        user_sizeY,
    input  logic              flip,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done,
    output logic              size_err
);

    typedef enum logic [1:0] {IDLE, SETUP, LOAD, FINISH} state_t;

    localparam logic [63:0] LIMIT = 64'd1 << ADDR_W;

    state_t            state, state_nxt;
    logic [9:0]        sx, sy, col, row;
    logic              err;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] addr;
    logic [19:0]       total;
    logic              size_bad;
    logic              xfer;
    logic              last_col;
    logic              last_pix;

`ifdef USER_SPRITE_WRITER_MIRROR_EN
    logic              flip_q;
`else
    logic              flip_unused;
    assign flip_unused = flip;
`endif

    assign total    = {10'd0, sx} * {10'd0, sy};
    assign size_bad = (sx == 10'd0) || (sy == 10'd0) || (64'(total) > LIMIT);
    assign last_col = (col == sx - 10'd1);
    assign last_pix = last_col && (row == sy - 10'd1);
    assign xfer     = in_valid && in_ready;

`ifdef USER_SPRITE_WRITER_MIRROR_EN
    assign addr = flip_q ? row_base + ADDR_W'(sx - 10'd1 - col)
                         : row_base + ADDR_W'(col);
`else
    assign addr = row_base + ADDR_W'(col);
`endif

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE:   if (load_start) state_nxt = SETUP;
            SETUP:  state_nxt = size_bad ? FINISH : LOAD;
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && last_pix) state_nxt = FINISH;
            end
            FINISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            we            <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            size_err      <= 1'b0;
            sx            <= '0;
            sy            <= '0;
            col           <= '0;
            row           <= '0;
            row_base      <= '0;
            err           <= 1'b0;
`ifdef USER_SPRITE_WRITER_MIRROR_EN
            flip_q        <= 1'b0;
`endif
        end else begin
            we       <= xfer;
            done     <= 1'b0;
            size_err <= 1'b0;
            if (xfer) begin
                write_address <= addr;
                write_data    <= in_data;
            end
            case (state)
                IDLE: if (load_start) begin
                    sx   <= user_sizeX;
                    sy   <= user_sizeY;
                    busy <= 1'b1;
`ifdef USER_SPRITE_WRITER_MIRROR_EN
                    flip_q <= flip;
`endif
                end
                SETUP: begin
                    err      <= size_bad;
                    col      <= '0;
                    row      <= '0;
                    row_base <= '0;
                end
                // Row base advances by sizeX per completed row, so no multiplier in the address path.
                LOAD: if (xfer) begin
                    if (last_col) begin
                        col      <= '0;
                        row      <= row + 10'd1;
                        row_base <= row_base + ADDR_W'(sx);
                    end else begin
                        col <= col + 10'd1;
                    end
                end
                FINISH: begin
                    done     <= 1'b1;
                    size_err <= err;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_user_sprite_writer.sv
// Scoreboard bench for user_sprite_writer: directed loads, expected writes queued, monitor compares.
module tb_user_sprite_writer;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 4;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              load_start;
    logic [9:0]        user_sizeX, user_sizeY;
    logic              flip;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready, we, busy, done, size_err;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] write_data;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  total = 0;
    int  bad = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;

    always #5 Clk = ~Clk;

    user_sprite_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .Clk(Clk), .Reset(Reset), .load_start(load_start),
        .user_sizeX(user_sizeX), .user_sizeY(user_sizeY), .flip(flip),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .we(we), .write_address(write_address), .write_data(write_data),
        .busy(busy), .done(done), .size_err(size_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (done === 1'b1) done_cnt++;
        if (we === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0d data %0d expected no write",
                         write_address, write_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 64'(write_address), 64'(mon_e.a));
                check("write_data", 64'(write_data), 64'(mon_e.d));
            end
        end
    end

    task automatic sync();
        @(posedge Clk);
        #1;
    endtask

    task automatic start(input int sx, input int sy, input bit fl);
        load_start = 1'b1;
        user_sizeX = 10'(sx);
        user_sizeY = 10'(sy);
        flip       = fl;
        sync();
        load_start = 1'b0;
    endtask

    // Feeds `count` pixels (data idx+1) and queues the address each accepted pixel must land at.
    task automatic stream(input int sx, input int sy, input bit fl, input bit gaps,
                          input int pulse_at, input int count);
        int   idx = 0;
        int   cyc = 0;
        int   busy_drop = 0;
        bit   v, mir, pulsed;
        logic r;
        wr_t  e;
        pulsed = 1'b0;
`ifdef USER_SPRITE_WRITER_MIRROR_EN
        mir = fl;
`else
        mir = 1'b0;
`endif
        while (idx < count && cyc < 200) begin
            v        = gaps ? (cyc % 2 == 0) : 1'b1;
            in_valid = v;
            in_data  = DATA_W'(idx + 1);
            if (!pulsed && idx == pulse_at) begin
                load_start = 1'b1;
                user_sizeX = 10'd2;
                user_sizeY = 10'd2;
                pulsed     = 1'b1;
            end
            @(negedge Clk);
            r = in_ready;
            if (busy !== 1'b1) busy_drop++;
            if (v && r === 1'b1) begin
                e.a = ADDR_W'((idx / sx) * sx + (mir ? (sx - 1 - idx % sx) : (idx % sx)));
                e.d = DATA_W'(idx + 1);
                exp_q.push_back(e);
            end
            sync();
            load_start = 1'b0;
            if (v && r === 1'b1) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_complete", 64'(idx), 64'(count));
        check("busy_held", 64'(busy_drop), 64'd0);
    endtask

    task automatic wait_done(input string name, input int lat, input bit err);
        int n = 0;
        bit rdy = 1'b0;
        do begin
            @(negedge Clk);
            n++;
            if (in_ready === 1'b1) rdy = 1'b1;
        end while (done !== 1'b1 && n < 20);
        check({name, "_done_latency"}, 64'(n), 64'(lat));
        check({name, "_size_err"}, 64'(size_err), 64'(err));
        check({name, "_ready_low"}, 64'(rdy), 64'd0);
        sync();
    endtask

    task automatic post(input string name, input int w0, input int d0, input int writes);
        repeat (4) sync();
        check({name, "_writes"}, 64'(wr_cnt - w0), 64'(writes));
        check({name, "_dones"}, 64'(done_cnt - d0), 64'd1);
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        check({name, "_busy_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, d0;
        Reset = 1'b1; load_start = 1'b0; user_sizeX = '0; user_sizeY = '0;
        flip = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) sync();
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_we", 64'(we), 64'd0);
        check("rst_addr", 64'(write_address), 64'd0);
        check("rst_data", 64'(write_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_size_err", 64'(size_err), 64'd0);
        sync();

        // Plain 4x2; a start is pulsed together with the final transfer and must be dropped.
        w0 = wr_cnt; d0 = done_cnt;
        start(4, 2, 1'b0);
        stream(4, 2, 1'b0, 1'b0, 7, 8);
        wait_done("plain", 2, 1'b0);
        post("plain", w0, d0, 8);

        w0 = wr_cnt; d0 = done_cnt;
        start(4, 2, 1'b1);
        stream(4, 2, 1'b1, 1'b0, -1, 8);
        wait_done("mirror", 2, 1'b0);
        post("mirror", w0, d0, 8);

        w0 = wr_cnt; d0 = done_cnt;
        start(3, 3, 1'b0);
        stream(3, 3, 1'b0, 1'b1, -1, 9);
        wait_done("gaps", 2, 1'b0);
        post("gaps", w0, d0, 9);

        w0 = wr_cnt; d0 = done_cnt;
        start(0, 5, 1'b0);
        in_valid = 1'b1;
        wait_done("zero_x", 3, 1'b1);
        in_valid = 1'b0;
        post("zero_x", w0, d0, 0);

        w0 = wr_cnt; d0 = done_cnt;
        start(1023, 1023, 1'b0);
        wait_done("too_big", 3, 1'b1);
        post("too_big", w0, d0, 0);

        w0 = wr_cnt; d0 = done_cnt;
        start(4, 4, 1'b0);
        stream(4, 4, 1'b0, 1'b0, 6, 16);
        wait_done("start_busy", 2, 1'b0);
        post("start_busy", w0, d0, 16);

        // Reset right after the 5th transfer: that write still lands, then everything stops.
        w0 = wr_cnt; d0 = done_cnt;
        start(4, 4, 1'b0);
        stream(4, 4, 1'b0, 1'b0, -1, 5);
        Reset = 1'b1;
        @(negedge Clk);
        sync();
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_mid_we", 64'(we), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_ready", 64'(in_ready), 64'd0);
        repeat (6) sync();
        check("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
        check("rst_mid_writes", 64'(wr_cnt - w0), 64'd5);

        w0 = wr_cnt; d0 = done_cnt;
        start(2, 1, 1'b0);
        stream(2, 1, 1'b0, 1'b0, -1, 2);
        wait_done("after_rst", 2, 1'b0);
        post("after_rst", w0, d0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/user_sprite_writer.md
# user_sprite_writer

Fills the user-fish sprite RAM with 4-bit palette indices, the write side of the address/data path that the user fish display logic reads from. Accepts a raster-ordered pixel stream over a valid/ready handshake, generates the RAM write address for a sprite of run-time size `sizeX` × `sizeY`, and signals completion. Optional horizontal mirroring lets the game reload the fish facing the other direction without storing a second image.

## Interface
Parameters:
- `ADDR_W`, default 19: RAM write address width; matches the read address width of the sprite RAM.
- `DATA_W`, default 4: palette index width.

Ports:
- `Clk`  in  1  50 MHz system clock; the only clock.
- `Reset`  in  1  synchronous, active-high reset.
- `load_start`  in  1  one-cycle request to begin a load; ignored while `busy`.
- `user_sizeX`, `user_sizeY`  in  10 each  sprite dimensions; sampled on the accepted `load_start`.
- `flip`  in  1  mirror horizontally; sampled with the sizes.
- `in_valid`  in  1  pixel stream valid.
- `in_data`  in  DATA_W  palette index, raster order, row 0 first, left to right.
- `in_ready`  out  1  block accepts a pixel this cycle.
- `we`  out  1  RAM write enable.
- `write_address`  out  ADDR_W  RAM write address.
- `write_data`  out  DATA_W  RAM write data.
- `busy`  out  1  high from the accepted start until `done`.
- `done`  out  1  one-cycle completion pulse.
- `size_err`  out  1  valid with `done`: load rejected.

## Operation
- States: IDLE, SETUP, LOAD, FINISH.
- IDLE: `load_start`=1 latches the sizes and `flip`, sets `busy`, and moves to SETUP.
- SETUP, one cycle: computes `total = sizeX*sizeY` at 20 bits.
  - If `sizeX`=0, `sizeY`=0, or `total` > 2^ADDR_W, go to FINISH with error set.
  - Otherwise clear the row base, set column = 0, and go to LOAD.
- LOAD: `in_ready`=1. A transfer happens when `in_valid && in_ready`.
  - Address = `row_base + col`, or `row_base + (sizeX-1-col)` when flipped.
  - `col` increments per transfer. When `col`=`sizeX-1`, `col` returns to 0 and `row_base += sizeX`. No multiplier is used in the datapath.
  - After the transfer with `row`=`sizeY-1` and `col`=`sizeX-1`, `in_ready` drops and the state moves to FINISH.
- FINISH: pulse `done` for one cycle. `size_err` is 1 only for a rejected load, else 0. Clear `busy`, return to IDLE.
- `load_start` while `busy` is dropped; there is no queueing.
- `in_valid` outside LOAD is ignored; no write occurs.

## Timing
- Reset values: `in_ready`=0, `we`=0, `write_address`=0, `write_data`=0, `busy`=0, `done`=0, `size_err`=0, state IDLE.
- Write latency is 1 cycle. A transfer at edge N produces `we`=1 with that address and data during cycle N+1. `we` is a registered single-cycle pulse per transfer.
- The first `in_ready` is asserted 2 cycles after the edge that accepts `load_start` (IDLE→SETUP→LOAD).
- Throughput is one pixel per cycle under continuous `in_valid`.
- `done` is asserted the cycle after the last `we` pulse.
- A rejected load gives `done`+`size_err` 2 cycles after start, with zero writes.
- `Reset` mid-load returns to IDLE at the next edge: `we` and `busy` go 0, and no `done` is issued. Partially written RAM content is left as is.
- Simultaneous `load_start` and the final transfer: the start is ignored because `busy` is still 1.

## Configuration
- `USER_SPRITE_WRITER_MIRROR_EN` defined: `flip` is honoured as described.
- Not defined: the `flip` port remains but is ignored, the address is always `row_base + col`, and the `sizeX-1-col` subtractor is not built.

## Test plan
- Plain load: 4×2, `flip`=0, continuous valid, data 1..8 → `we` at addresses 0,1,2,3,4,5,6,7 with data 1..8. `done` one cycle after the last write; `size_err`=0.
- Mirrored load (macro defined): 4×2, `flip`=1, data 1..8 → addresses 3,2,1,0,7,6,5,4. Same test without the macro → addresses 0..7.
- Backpressure gaps: 3×3, `in_valid` toggling 1,0,1,0… → exactly 9 writes at addresses 0..8 in order. No write in gap cycles; `busy` held throughout.
- Size errors:
  - `sizeX`=0, `sizeY`=5 → `done`=1 with `size_err`=1 two cycles after start, zero writes, `in_ready` never high.
  - 1023×1023 → same response, since 1046529 > 524288.
- Start while busy: `load_start` pulsed mid-load of a 4×4 sprite → ignored. Exactly 16 writes, a single `done`.
- Reset mid-load: `Reset` after the 5th transfer of 4×4 → next cycle `we`=0, `busy`=0, no `done`. A new 2×1 load then writes addresses 0,1 correctly.
